// File: rtl/joypad_link_pkg.sv
// Shared definitions for the joypad serial link (target and initiator sides).
package joypad_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX,
    ST_MACK,
    ST_TX_LOAD,
    ST_IGNORE
  } jp_state_e;

  localparam logic [6:0] JOYPAD_TARGET_ADDR = 7'h20;
  localparam logic       RW_READ            = 1'b1;

endpackage

// File: rtl/pin_sync.sv
// N-flop synchroniser for one asynchronous pin; resets to the idle bus level.
module pin_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ff <= {N{RST_VAL}};
    else        r_ff <= {r_ff[N-2:0], i_d};
  end

  assign o_q = r_ff[N-1];

endmodule

// File: rtl/joypad_target.sv
// Read-only I2C-subset target: answers its address with a read and streams a
// snapshot of the button bytes, LSB byte first, MSB bit first. Open-drain sda.
module joypad_target
  import joypad_link_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = JOYPAD_TARGET_ADDR,
  parameter int         NUM_BYTES   = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda_oe,
  input  logic [8*NUM_BYTES-1:0] pad_state,
  output logic                   busy,
  output logic                   snap_pulse
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic w_scl_s, w_sda_s;
  logic r_scl_d, r_sda_d;

  pin_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scl (
    .clk(clk), .rst_n(rst_n), .i_d(scl_in), .o_q(w_scl_s)
  );
  pin_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sda (
    .clk(clk), .rst_n(rst_n), .i_d(sda_in), .o_q(w_sda_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl_s;
      r_sda_d <= w_sda_s;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  // scl must be high on both sides of the sda edge to count as a bus condition
  assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

  jp_state_e                     r_state, w_nxt_state;
  logic [3:0]                    r_bit_cnt, w_nxt_bit_cnt;
  logic [6:0]                    r_shift, w_nxt_shift;
  logic [IDX_W-1:0]              r_byte_idx, w_nxt_byte_idx;
  logic [NUM_BYTES-1:0][7:0]     r_snap;
  logic                          r_sda_oe, w_nxt_sda_oe;
  logic                          r_busy, w_nxt_busy;
  logic                          r_snap_pulse;
  logic                          w_capture;

  logic [7:0] w_cur_byte;
  logic       w_tx_bit;
  assign w_cur_byte = r_snap[r_byte_idx];
  // bit_cnt counts bits already presented, so the next one is bit 7-bit_cnt
  assign w_tx_bit   = w_cur_byte[~r_bit_cnt[2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_idx   <= '0;
      r_snap       <= '0;
      r_sda_oe     <= 1'b0;
      r_busy       <= 1'b0;
      r_snap_pulse <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_bit_cnt    <= w_nxt_bit_cnt;
      r_shift      <= w_nxt_shift;
      r_byte_idx   <= w_nxt_byte_idx;
      r_sda_oe     <= w_nxt_sda_oe;
      r_busy       <= w_nxt_busy;
      r_snap_pulse <= w_capture;
      if (w_capture) r_snap <= pad_state;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_bit_cnt  = r_bit_cnt;
    w_nxt_shift    = r_shift;
    w_nxt_byte_idx = r_byte_idx;
    w_nxt_sda_oe   = r_sda_oe;
    w_nxt_busy     = r_busy;
    w_capture      = 1'b0;
    if (w_stop) begin
      w_nxt_state   = ST_IDLE;
      w_nxt_sda_oe  = 1'b0;
      w_nxt_busy    = 1'b0;
      w_nxt_bit_cnt = '0;
    end else if (w_start) begin
      w_nxt_state   = ST_ADDR;
      w_nxt_sda_oe  = 1'b0;
      w_nxt_busy    = 1'b1;
      w_nxt_bit_cnt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: w_nxt_sda_oe = 1'b0;
        ST_ADDR: if (w_scl_rise) begin
          w_nxt_shift   = {r_shift[5:0], w_sda_s};
          w_nxt_bit_cnt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_nxt_bit_cnt = '0;
            // r_shift holds the 7 address bits; the bit arriving now is R/W
            if (r_shift == TARGET_ADDR && w_sda_s == RW_READ) begin
              w_capture      = 1'b1;
              w_nxt_byte_idx = '0;
              w_nxt_state    = ST_ADDR_ACK;
            end else begin
              w_nxt_state = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd0) begin
            w_nxt_sda_oe  = 1'b1;
            w_nxt_bit_cnt = 4'd1;
          end else begin
            w_nxt_sda_oe  = ~w_cur_byte[7];
            w_nxt_bit_cnt = 4'd1;
            w_nxt_state   = ST_TX;
          end
        end
        ST_TX: if (w_scl_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_nxt_sda_oe = 1'b0;
            w_nxt_state  = ST_MACK;
          end else begin
            w_nxt_sda_oe  = ~w_tx_bit;
            w_nxt_bit_cnt = r_bit_cnt + 4'd1;
          end
        end
        ST_MACK: if (w_scl_rise) begin
          if (!w_sda_s) begin
            w_nxt_byte_idx = (r_byte_idx == IDX_W'(NUM_BYTES-1)) ? '0 : r_byte_idx + 1'b1;
            w_nxt_state    = ST_TX_LOAD;
          end else begin
            w_nxt_state = ST_IGNORE;
          end
        end
        ST_TX_LOAD: if (w_scl_fall) begin
          w_nxt_sda_oe  = ~w_cur_byte[7];
          w_nxt_bit_cnt = 4'd1;
          w_nxt_state   = ST_TX;
        end
        ST_IGNORE: w_nxt_sda_oe = 1'b0;
        default: begin
          w_nxt_state  = ST_IDLE;
          w_nxt_sda_oe = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign snap_pulse = r_snap_pulse;

endmodule

// File: tb/tb_joypad_target.sv
// Bench for joypad_target: bit-banged initiator, table of frames, scoreboard of read bytes.
module tb_joypad_target;
  localparam int Q = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [31:0] pad = 32'hA53C0F81;
  logic        sda_oe, busy, snap_pulse;
  logic        sda_in;

  assign sda_in = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  joypad_target #(.TARGET_ADDR(7'h20), .NUM_BYTES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .pad_state(pad), .busy(busy), .snap_pulse(snap_pulse)
  );

  int n_vec = 0, n_bad = 0;
  int snap_cnt = 0, oe_cnt = 0;

  always @(negedge clk) begin
    if (snap_pulse) snap_cnt <= snap_cnt + 1;
    if (sda_oe)     oe_cnt   <= oe_cnt + 1;
  end

  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bit_w(input logic b);
    scl = 1'b0; #Q; m_sda = b; #Q; scl = 1'b1; #(2*Q);
  endtask

  task automatic bit_r(output logic b);
    scl = 1'b0; #Q; m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda_in; #Q;
  endtask

  task automatic start_c;
    scl = 1'b0; #Q; m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q;
  endtask

  task automatic stop_c;
    scl = 1'b0; #Q; m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #Q;
  endtask

  // One frame without the STOP; the model snapshot is pad as seen at the address phase.
  task automatic do_xfer(input logic [6:0] addr, input logic rw, input int nbytes,
                         input logic nack_last, input logic chg_pad, output logic ack);
    logic [7:0]  a;
    logic [7:0]  rd;
    logic [31:0] snap;
    logic        b;
    a = {addr, rw};
    start_c();
    for (int i = 7; i >= 0; i--) bit_w(a[i]);
    bit_r(b);
    ack  = ~b;
    snap = pad;
    if (chg_pad) pad = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (ack) begin
        exp_q.push_back(snap[(i%4)*8 +: 8]);
        rd = '0;
        for (int j = 0; j < 8; j++) begin
          bit_r(b);
          rd = {rd[6:0], b};
        end
        chk("rd_byte", {24'h0, rd}, {24'h0, exp_q.pop_front()});
        bit_w((i == nbytes-1) && nack_last);
      end else begin
        for (int j = 0; j < 9; j++) bit_w(rw ? 1'b1 : 1'(j % 2));
      end
    end
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    int         nbytes;
    logic       nack_last;
    logic       exp_ack;
    int         exp_snaps;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic ack;
    int   c_snap, c_oe, c2;

    tbl[0] = '{7'h20, 1'b1, 4, 1'b0, 1'b1, 1};
    tbl[1] = '{7'h21, 1'b1, 1, 1'b0, 1'b0, 0};
    tbl[2] = '{7'h20, 1'b0, 1, 1'b0, 1'b0, 0};
    tbl[3] = '{7'h20, 1'b1, 6, 1'b1, 1'b1, 1};

    #100;
    chk("rst_oe",   {31'h0, sda_oe},     32'h0);
    chk("rst_busy", {31'h0, busy},       32'h0);
    chk("rst_snap", {31'h0, snap_pulse}, 32'h0);
    rst_n = 1'b1;
    #100;

    for (int v = 0; v < 4; v++) begin
      pad    = 32'hA53C0F81;
      c_snap = snap_cnt;
      c_oe   = oe_cnt;
      do_xfer(tbl[v].addr, tbl[v].rw, tbl[v].nbytes, tbl[v].nack_last, 1'b0, ack);
      chk("addr_ack", {31'h0, ack}, {31'h0, tbl[v].exp_ack});
      chk("busy_in_frame", {31'h0, busy}, 32'h1);
      c2 = oe_cnt;
      stop_c();
      #100;
      chk("busy_after_stop", {31'h0, busy}, 32'h0);
      chk("snap_count", snap_cnt - c_snap, tbl[v].exp_snaps);
      if (!tbl[v].exp_ack) chk("no_drive", oe_cnt - c_oe, 0);
      if (tbl[v].nack_last) chk("rel_after_nack", oe_cnt - c2, 0);
    end

    // snapshot stability, then repeated START picks up the new pad value
    pad    = 32'hA53C0F81;
    c_snap = snap_cnt;
    do_xfer(7'h20, 1'b1, 1, 1'b1, 1'b1, ack);
    chk("snap1_ack", {31'h0, ack}, 32'h1);
    do_xfer(7'h20, 1'b1, 1, 1'b1, 1'b0, ack);
    chk("snap2_ack", {31'h0, ack}, 32'h1);
    chk("busy_rstart", {31'h0, busy}, 32'h1);
    stop_c();
    #100;
    chk("snap_pulses", snap_cnt - c_snap, 2);

    // reset while the address ACK is being driven
    pad = 32'hA53C0F81;
    start_c();
    for (int i = 7; i >= 0; i--) bit_w(1'(8'h41 >> i));
    scl = 1'b0;
    #(Q+20);
    chk("ack_before_rst", {31'h0, sda_oe}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe",   {31'h0, sda_oe}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy},   32'h0);
    #9; #40;
    rst_n = 1'b1;
    c_oe = oe_cnt;
    for (int j = 0; j < 9; j++) bit_w(1'(j % 2));
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_idle", oe_cnt - c_oe, 0);
    stop_c();
    do_xfer(7'h20, 1'b1, 1, 1'b1, 1'b0, ack);
    chk("recover_ack", {31'h0, ack}, 32'h1);
    stop_c();
    #100;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
